// File: rtl/imem_arb.sv
// rtl/imem_arb.sv - two-requester instruction memory read arbiter
// Fetch has priority; debug wins after MAXWAIT consecutive denied cycles.
module imem_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_valid,
  output logic [DW-1:0] f_inst,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_inst,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_inst
);

  localparam int WW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAXWAIT);

  typedef enum logic [1:0] {IDLE, FETCH, DEBUG} state_t;

  state_t        state, state_nx;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic [AW-1:0] addr_q;

  // Grants are gated by rst so nothing is issued while reset is held.
  always_comb begin
    f_gnt    = 1'b0;
    d_gnt    = 1'b0;
    state_nx = IDLE;
    wcnt_nx  = '0;
    mem_addr = addr_q;
    if (!rst) begin
      f_gnt = f_req && (wcnt < WMAX);
      d_gnt = d_req && (!f_req || (wcnt == WMAX));
    end
    if (f_gnt) begin
      state_nx = FETCH;
      mem_addr = f_addr;
    end else if (d_gnt) begin
      state_nx = DEBUG;
      mem_addr = d_addr;
    end
    if (d_req && !d_gnt)
      wcnt_nx = (wcnt == WMAX) ? wcnt : wcnt + WW'(1);
  end

  assign f_valid = (state == FETCH);
  assign d_valid = (state == DEBUG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wcnt   <= '0;
      addr_q <= '0;
      f_inst <= '0;
      d_inst <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (f_gnt || d_gnt)
        addr_q <= mem_addr;
      if (f_gnt)
        f_inst <= mem_inst;
      if (d_gnt)
        d_inst <= mem_inst;
    end
  end

endmodule

// File: tb/tb_imem_arb.sv
// tb/tb_imem_arb.sv - directed self-checking bench for imem_arb
module tb_imem_arb;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_valid;
  logic [31:0] f_inst;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_inst;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;

  logic [31:0] imem [0:255];

  int n_cmp = 0;
  int n_err = 0;

  imem_arb #(.AW(32), .DW(32), .MAXWAIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_valid  (f_valid),
    .f_inst   (f_inst),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_gnt    (d_gnt),
    .d_valid  (d_valid),
    .d_inst   (d_inst),
    .mem_addr (mem_addr),
    .mem_inst (mem_inst)
  );

  assign mem_inst = imem[mem_addr[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    imem[0]   = 32'd0;
    imem[1]   = 32'd127;
    imem[10]  = 32'd33;
    imem[100] = 32'd55;

    rst = 1'b1; f_req = 1'b1; f_addr = 32'd1; d_req = 1'b1; d_addr = 32'd10;
    #2;
    chk("rst_fgnt", f_gnt, 0);
    chk("rst_dgnt", d_gnt, 0);
    chk("rst_fvalid", f_valid, 0);
    chk("rst_dvalid", d_valid, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_finst", f_inst, 0);
    chk("rst_dinst", d_inst, 0);
    tick();
    f_req = 1'b0; d_req = 1'b0;
    tick();
    rst = 1'b0;

    // single fetch at addr 1
    f_req = 1'b1; f_addr = 32'd1;
    #1;
    chk("f1_gnt", f_gnt, 1);
    chk("f1_dgnt", d_gnt, 0);
    chk("f1_maddr", mem_addr, 1);
    tick();
    f_req = 1'b0;
    #1;
    chk("f1_valid", f_valid, 1);
    chk("f1_inst", f_inst, 127);
    chk("f1_dvalid", d_valid, 0);

    // single debug at addr 10
    tick();
    d_req = 1'b1; d_addr = 32'd10;
    #1;
    chk("d1_gnt", d_gnt, 1);
    chk("d1_fgnt", f_gnt, 0);
    chk("d1_maddr", mem_addr, 10);
    tick();
    d_req = 1'b0;
    #1;
    chk("d1_valid", d_valid, 1);
    chk("d1_inst", d_inst, 33);
    chk("d1_finst", f_inst, 127);
    chk("d1_fvalid", f_valid, 0);

    // back-to-back fetch at 0,1,10
    tick();
    f_req = 1'b1; f_addr = 32'd0;
    #1;
    chk("b2b_gnt0", f_gnt, 1);
    tick();
    f_addr = 32'd1;
    #1;
    chk("b2b_v0", f_valid, 1);
    chk("b2b_i0", f_inst, 0);
    tick();
    f_addr = 32'd10;
    #1;
    chk("b2b_v1", f_valid, 1);
    chk("b2b_i1", f_inst, 127);
    tick();
    f_req = 1'b0;
    #1;
    chk("b2b_v2", f_valid, 1);
    chk("b2b_i2", f_inst, 33);
    tick();
    chk("b2b_end", f_valid, 0);

    // contention: debug wins every 5th cycle
    d_inst_clear_check();
    f_req = 1'b1; f_addr = 32'd1; d_req = 1'b1; d_addr = 32'd10;
    for (int c = 0; c < 15; c++) begin
      #1;
      chk($sformatf("mw_fgnt%0d", c), f_gnt, (c % 5) != 4);
      chk($sformatf("mw_dgnt%0d", c), d_gnt, (c % 5) == 4);
      chk($sformatf("mw_addr%0d", c), mem_addr, ((c % 5) == 4) ? 10 : 1);
      if (c > 0) begin
        chk($sformatf("mw_fv%0d", c), f_valid, ((c - 1) % 5) != 4);
        chk($sformatf("mw_dv%0d", c), d_valid, ((c - 1) % 5) == 4);
      end
      tick();
    end
    f_req = 1'b0; d_req = 1'b0;
    #1;
    chk("mw_last_dv", d_valid, 1);
    chk("mw_dinst", d_inst, 33);
    chk("mw_finst", f_inst, 127);
    tick();

    // async reset during the valid cycle drops the response
    f_req = 1'b1; f_addr = 32'd1;
    tick();
    f_req = 1'b0;
    chk("ar_pre_valid", f_valid, 1);
    rst = 1'b1;
    #1;
    chk("ar_fvalid", f_valid, 0);
    chk("ar_finst", f_inst, 0);
    chk("ar_maddr", mem_addr, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("ar_post%0d", c), f_valid, 0);
    end

    // idle after grant at 100: mem_addr holds
    f_req = 1'b1; f_addr = 32'd100;
    tick();
    f_req = 1'b0; f_addr = 32'd5; d_addr = 32'd6;
    #1;
    chk("id_valid", f_valid, 1);
    chk("id_inst", f_inst, 55);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("id_maddr%0d", c), mem_addr, 100);
      chk($sformatf("id_fv%0d", c), f_valid, 0);
      chk($sformatf("id_dv%0d", c), d_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  task automatic d_inst_clear_check();
    chk("pre_mw_dinst", d_inst, 33);
  endtask

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 SHALL have parameter AW, default 32, meaning instruction address width in bits.
REQ-002 SHALL have parameter DW, default 32, meaning instruction word width in bits.
REQ-003 SHALL have parameter MAXWAIT, default 4, meaning consecutive denied debug cycles before debug is forced to win.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-006 SHALL have port f_req  input  1  meaning fetch requester requests a read.
REQ-007 SHALL have port f_addr  input  AW  meaning fetch word address.
REQ-008 SHALL have port f_gnt  output  1  meaning fetch request granted this cycle.
REQ-009 SHALL have port f_valid  output  1  meaning f_inst carries the word for the previous fetch grant.
REQ-010 SHALL have port f_inst  output  DW  meaning registered fetch read data.
REQ-011 SHALL have port d_req  input  1  meaning debug/loader requester requests a read.
REQ-012 SHALL have port d_addr  input  AW  meaning debug word address.
REQ-013 SHALL have port d_gnt  output  1  meaning debug request granted this cycle.
REQ-014 SHALL have port d_valid  output  1  meaning d_inst carries the word for the previous debug grant.
REQ-015 SHALL have port d_inst  output  DW  meaning registered debug read data.
REQ-016 SHALL have port mem_addr  output  AW  meaning address driven to imem addr.
REQ-017 SHALL have port mem_inst  input  DW  meaning combinational read data from imem inst.

Function
REQ-018 SHALL grant at most one requester per cycle; f_gnt and d_gnt are combinational from req inputs and the wait counter and never both high.
REQ-019 SHALL give fetch priority: f_req high and wait counter below MAXWAIT -> f_gnt.
REQ-020 SHALL grant debug when d_req high and (f_req low or wait counter equals MAXWAIT).
REQ-021 SHALL keep a wait counter (width ceil(log2(MAXWAIT+1))): +1 each cycle d_req high and d_gnt low; cleared on d_gnt or d_req low; saturates at MAXWAIT.
REQ-022 SHALL drive mem_addr combinationally with the granted requester's address; with no grant, mem_addr holds the last granted address (register, reset 0).
REQ-023 SHALL capture mem_inst at the rising edge ending a grant cycle into f_inst or d_inst of the granted port; read latency exactly 1 cycle from grant to valid.
REQ-024 SHALL assert f_valid / d_valid for exactly one cycle per grant; back-to-back grants give back-to-back valid cycles.
REQ-025 SHALL hold f_inst and d_inst unchanged between captures; the non-granted port's data is never overwritten.
REQ-026 SHALL implement a 3-state owner FSM: IDLE (no grant last cycle), FETCH (fetch granted last cycle), DEBUG (debug granted last cycle); next state = owner of current grant, IDLE if none; f_valid = (state==FETCH), d_valid = (state==DEBUG).
REQ-027 SHALL require requesters to hold req and addr stable until granted; req may drop in the cycle after grant; a held req after grant is a new request.
REQ-028 SHALL, when f_req and d_req are high on the same cycle with counter at MAXWAIT, grant debug, clear the counter, and grant fetch next cycle if f_req remains high.
REQ-029 SHALL treat all addresses as opaque; no range check, no wrap logic, full AW bits passed through.

Reset
REQ-030 SHALL, while rst high, force state IDLE, wait counter 0, mem_addr register 0, f_inst 0, d_inst 0, f_valid 0, d_valid 0, f_gnt 0, d_gnt 0.
REQ-031 SHALL, on rst asserted in the cycle after a grant, drop the pending valid; no response is delivered for that grant after reset release.
REQ-032 SHALL resume arbitration on the first rising clk edge after rst deasserts.

Verification
REQ-033 Bench SHALL cover: imem[1]=127, f_req=1,f_addr=1, d_req=0 -> f_gnt same cycle, next cycle f_valid=1,f_inst=127, d_valid=0.
REQ-034 Bench SHALL cover: imem[10]=33, d_req=1,d_addr=10, f_req=0 -> d_gnt same cycle, mem_addr=10, next cycle d_valid=1,d_inst=33, f_inst unchanged.
REQ-035 Bench SHALL cover: f_req and d_req held high continuously, MAXWAIT=4 -> f_gnt 4 cycles, d_gnt on 5th, f_gnt resumes on 6th; pattern repeats.
REQ-036 Bench SHALL cover: fetch grants at addr 0,1,10 on consecutive cycles with imem[0]=0 -> f_valid high 3 consecutive cycles, f_inst 0,127,33.
REQ-037 Bench SHALL cover: rst pulsed high asynchronously the cycle after f_gnt at addr 1 -> f_valid stays 0, f_inst=0, mem_addr=0, no valid after release.
REQ-038 Bench SHALL cover: no requests for 3 cycles after a grant at addr 100 -> mem_addr holds 100, both valids 0, state IDLE.
